// File: rtl/ram_stream_reader.sv
// Streams a range of words out of a synchronous-read single-port RAM as a valid/ready stream.
// At most two words are ever in flight or buffered, so backpressure never drops data.
module ram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   // state | meaning
   // IDLE  | waiting for start; a zero-length start only pulses done
   // READ  | issuing RAM reads while the buffer has room
   // DRAIN | all reads issued, waiting for the final word to be accepted
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH:0]     remaining;
   logic                    inflight;
   logic                    inflight_last;
   logic [1:0]              occ;
   logic [DATA_WIDTH-1:0]   tail_data;
   logic                    tail_last;
   logic                    pop;
   logic                    issue;
   logic [2:0]              pending;

   assign ram_we   = 1'b0;
   assign ram_addr = addr;
   assign pop      = out_valid && out_ready;
   // Slots committed after this cycle's pop; a new read only goes out if it still fits.
   assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue    = (state == READ) && (remaining != '0) && (pending < 3'd2);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         occ           <= 2'd0;
         tail_data     <= '0;
         tail_last     <= 1'b0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done          <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remaining == REM_ONE);
         if (issue) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     addr      <= base_addr;
                     remaining <= length;
                     busy      <= 1'b1;
                     state     <= READ;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue && (remaining == REM_ONE)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && out_last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Two-entry buffer: head drives the stream, tail holds the overflow word.
         case ({pop, inflight})
            2'b10: begin
               if (occ == 2'd2) begin
                  out_data <= tail_data;
                  out_last <= tail_last;
                  occ      <= 2'd1;
               end else begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  occ       <= 2'd0;
               end
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  out_data  <= tail_data;
                  out_last  <= tail_last;
                  tail_data <= ram_q;
                  tail_last <= inflight_last;
               end else begin
                  out_data <= ram_q;
                  out_last <= inflight_last;
               end
            end
            2'b01: begin
               if (occ == 2'd0) begin
                  out_data  <= ram_q;
                  out_last  <= inflight_last;
                  out_valid <= 1'b1;
                  occ       <= 2'd1;
               end else begin
                  tail_data <= ram_q;
                  tail_last <= inflight_last;
                  occ       <= 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a behavioural RAM, per-transfer expected word lists and
// stream-rule checks applied every cycle.
module tb_ram_stream_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] base_addr;
   logic [3:0] length;
   logic       busy;
   logic       done;
   logic [2:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_q;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   logic [7:0] mem [8];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= 8'hEE;
      ram_q <= mem[ram_addr];
   end

   ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   typedef struct {
      int base;
      int len;
      int first_valid;
      int done_cyc;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
   endtask

   // mode 0: ready always high; 1: random ready; 2: stall cycles 4-8 then 1010...
   // inject: second start while busy; rst_after: assert reset after that many words.
   task automatic run_xfer(input int base, input int len, input int mode, input bit inject,
                           input int rst_after, output int first_v, output int done_c);
      int  exp_w [8];
      int  delivered = 0;
      int  last_hs = -1;
      bit  pv = 0, pr = 0, pl = 0;
      int  pd = 0;
      bit  rst_hit = 0;
      for (int i = 0; i < len; i++) exp_w[i] = int'(mem[(base + i) % 8]);
      first_v = -1;
      done_c  = -1;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (c == 0) begin
            start     = 1'b1;
            base_addr = 3'(base);
            length    = 4'(len);
         end else if (inject && c == 4) begin
            start     = 1'b1;
            base_addr = 3'd3;
            length    = 4'd2;
         end else begin
            start = 1'b0;
         end
         case (mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = (c >= 4 && c <= 8) ? 1'b0 : (c >= 9 ? ((c - 9) % 2 == 0) : 1'b1);
            default: out_ready = 1'b1;
         endcase
         if (c == 1) chk("busy_cycle1", busy, (len != 0) ? 1 : 0);
         if (mode == 0 && c >= 1 && c <= len) chk("ram_addr_seq", ram_addr, (base + c - 1) % 8);
         if (len == 0) chk("no_valid_len0", out_valid, 0);
         if (out_valid && first_v < 0) first_v = c;
         if (pv && !pr) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, pd);
            chk("hold_last", out_last, pl);
         end
         if (out_valid && out_ready) begin
            if (delivered >= len) begin
               chk("extra_word", delivered, len - 1);
            end else begin
               chk("out_data", out_data, exp_w[delivered]);
               chk("out_last", out_last, (delivered == len - 1) ? 1 : 0);
            end
            delivered++;
            last_hs = c;
         end
         if (done) begin
            done_c = c;
            chk("busy_at_done", busy, 0);
            break;
         end
         if (rst_after > 0 && delivered == rst_after) begin
            reset = 1'b1;
            start = 1'b0;
            tick();
            reset = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            rst_hit = 1;
            break;
         end
         pv = out_valid;
         pr = out_ready;
         pd = int'(out_data);
         pl = out_last;
      end
      out_ready = 1'b1;
      start     = 1'b0;
      if (!rst_hit) begin
         if (done_c < 0) chk("done_timeout", 0, 1);
         chk("word_count", delivered, len);
         if (len > 0) chk("done_after_last", done_c, last_hs + 1);
         tick();
         chk("done_one_pulse", done, 0);
      end
   endtask

   initial begin
      int fv, dc;
      vecs[0] = '{base: 0, len: 8, first_valid: 3,  done_cyc: 11};
      vecs[1] = '{base: 6, len: 4, first_valid: 3,  done_cyc: 7};
      vecs[2] = '{base: 5, len: 1, first_valid: 3,  done_cyc: 4};
      vecs[3] = '{base: 7, len: 2, first_valid: 3,  done_cyc: 5};
      vecs[4] = '{base: 3, len: 0, first_valid: -1, done_cyc: 1};

      preload();
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
      repeat (3) tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_last", out_last, 0);
      chk("reset_data", out_data, 0);
      chk("reset_ram_addr", ram_addr, 0);
      chk("ram_we_zero", ram_we, 0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         run_xfer(vecs[v].base, vecs[v].len, 0, 0, 0, fv, dc);
         chk("first_valid_cycle", fv, vecs[v].first_valid);
         chk("done_cycle", dc, vecs[v].done_cyc);
      end

      // Backpressure: stall window then alternating ready.
      run_xfer(0, 8, 2, 0, 0, fv, dc);
      // Start while busy must not disturb the running transfer.
      run_xfer(0, 8, 0, 1, 0, fv, dc);
      chk("inject_done_cycle", dc, 11);
      // Reset mid-transfer, then a fresh short transfer.
      run_xfer(0, 8, 0, 0, 3, fv, dc);
      run_xfer(2, 2, 0, 0, 0, fv, dc);
      chk("post_reset_done_cycle", dc, 5);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
         run_xfer(int'($urandom_range(0, 7)), int'($urandom_range(1, 8)), 1, 0, 0, fv, dc);
      end
      preload();
      run_xfer(int'($urandom_range(0, 7)), 8, 1, 0, 0, fv, dc);

      chk("ram_we_end", ram_we, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
